// File: rtl/line_draw_pkg.sv
// Shared constants and types for the memory-mapped Bresenham line engine.
package line_draw_pkg;

  localparam logic [11:0] DEF_BASE_ADDR = 12'hF00;
  localparam int          DEF_X_W       = 10;
  localparam int          DEF_Y_W       = 9;
  localparam int          DEF_COLOR_W   = 8;

  localparam int unsigned N_REGS = 6;
  localparam logic [2:0]  OFF_X0    = 3'd0;
  localparam logic [2:0]  OFF_Y0    = 3'd1;
  localparam logic [2:0]  OFF_X1    = 3'd2;
  localparam logic [2:0]  OFF_Y1    = 3'd3;
  localparam logic [2:0]  OFF_COLOR = 3'd4;
  localparam logic [2:0]  OFF_GO    = 3'd5;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_draw_engine_if.sv
// Processor store snoop port plus framebuffer pixel handshake.
interface line_draw_engine_if #(
  parameter int X_W     = line_draw_pkg::DEF_X_W,
  parameter int Y_W     = line_draw_pkg::DEF_Y_W,
  parameter int COLOR_W = line_draw_pkg::DEF_COLOR_W
);
  logic [11:0]        dmem_address;
  logic [31:0]        dmem_data_in;
  logic               ctrl_DMWE;
  logic               busy;
  logic               dropped;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_we;
  logic               pix_ready;

  modport master (
    output dmem_address, dmem_data_in, ctrl_DMWE, pix_ready,
    input  busy, dropped, pix_x, pix_y, pix_color, pix_we
  );

  modport slave (
    input  dmem_address, dmem_data_in, ctrl_DMWE, pix_ready,
    output busy, dropped, pix_x, pix_y, pix_color, pix_we
  );
endinterface

// File: rtl/line_draw_regs.sv
// Register window decode: shadow endpoint/color registers, GO strobe and dropped pulse.
module line_draw_regs
  import line_draw_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          X_W       = DEF_X_W,
  parameter int          Y_W       = DEF_Y_W,
  parameter int          COLOR_W   = DEF_COLOR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        i_addr,
  input  logic [31:0]        i_data,
  input  logic               i_we,
  input  logic               i_idle,
  output logic [X_W-1:0]     o_x0,
  output logic [Y_W-1:0]     o_y0,
  output logic [X_W-1:0]     o_x1,
  output logic [Y_W-1:0]     o_y1,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_go,
  output logic               o_dropped
);

  localparam int D_W = max_w(X_W, max_w(Y_W, COLOR_W));

  logic [11:0] w_off;
  logic        w_hit;
  logic        w_unused_data;

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign w_off         = i_addr - BASE_ADDR;
  assign w_hit         = i_we && (w_off < 12'(N_REGS));
  assign o_go          = w_hit && (w_off[2:0] == OFF_GO);
  assign w_unused_data = ^i_data[31:D_W];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_x0      <= '0;
      o_y0      <= '0;
      o_x1      <= '0;
      o_y1      <= '0;
      o_color   <= '0;
      o_dropped <= 1'b0;
    end else begin
      o_dropped <= o_go && !i_idle;
      if (w_hit) begin
        case (w_off[2:0])
          OFF_X0:    o_x0    <= i_data[X_W-1:0];
          OFF_Y0:    o_y0    <= i_data[Y_W-1:0];
          OFF_X1:    o_x1    <= i_data[X_W-1:0];
          OFF_Y1:    o_y1    <= i_data[Y_W-1:0];
          OFF_COLOR: o_color <= i_data[COLOR_W-1:0];
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/line_draw_engine.sv
// Turtle line rasterizer: FSM plus Bresenham stepper emitting one pixel per accepted handshake.
module line_draw_engine
  import line_draw_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          X_W       = DEF_X_W,
  parameter int          Y_W       = DEF_Y_W,
  parameter int          COLOR_W   = DEF_COLOR_W
) (
  input logic              clock,
  input logic              reset,
  line_draw_engine_if.slave bus
);

  localparam int E_W = max_w(X_W, Y_W) + 2;

  state_t r_state, w_next_state;

  logic [X_W-1:0]     w_sh_x0, w_sh_x1;
  logic [Y_W-1:0]     w_sh_y0, w_sh_y1;
  logic [COLOR_W-1:0] w_sh_color;
  logic               w_go;
  logic               w_dropped;

  logic [X_W-1:0]     r_x, r_x1;
  logic [Y_W-1:0]     r_y, r_y1;
  logic [COLOR_W-1:0] r_color;
  logic               r_sx_neg, r_sy_neg;
  logic signed [E_W-1:0] r_dx, r_dy, r_err;

  logic [X_W-1:0]        w_adx;
  logic [Y_W-1:0]        w_ady;
  logic signed [E_W-1:0] w_e2, w_err_next;
  logic                  w_step_x, w_step_y, w_at_end;

  line_draw_regs #(
    .BASE_ADDR (BASE_ADDR),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .COLOR_W   (COLOR_W)
  ) u_regs (
    .clock     (clock),
    .reset     (reset),
    .i_addr    (bus.dmem_address),
    .i_data    (bus.dmem_data_in),
    .i_we      (bus.ctrl_DMWE),
    .i_idle    (r_state == IDLE),
    .o_x0      (w_sh_x0),
    .o_y0      (w_sh_y0),
    .o_x1      (w_sh_x1),
    .o_y1      (w_sh_y1),
    .o_color   (w_sh_color),
    .o_go      (w_go),
    .o_dropped (w_dropped)
  );

  assign w_adx      = (r_x1 >= r_x) ? (r_x1 - r_x) : (r_x - r_x1);
  assign w_ady      = (r_y1 >= r_y) ? (r_y1 - r_y) : (r_y - r_y1);
  assign w_e2       = r_err <<< 1;
  assign w_step_x   = (w_e2 >= r_dy);
  assign w_step_y   = (w_e2 <= r_dx);
  assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
  assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_go) w_next_state = SETUP;
      SETUP:   w_next_state = DRAW;
      DRAW:    if (bus.pix_ready && w_at_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_color  <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_go) begin
          r_x     <= w_sh_x0;
          r_y     <= w_sh_y0;
          r_x1    <= w_sh_x1;
          r_y1    <= w_sh_y1;
          r_color <= w_sh_color;
        end
        SETUP: begin
          r_dx     <= E_W'(w_adx);
          r_dy     <= -$signed(E_W'(w_ady));
          r_err    <= $signed(E_W'(w_adx)) - $signed(E_W'(w_ady));
          r_sx_neg <= (r_x1 < r_x);
          r_sy_neg <= (r_y1 < r_y);
        end
        // Stalled handshakes leave every working register, hence every pixel output, untouched.
        DRAW: if (bus.pix_ready && !w_at_end) begin
          r_err <= w_err_next;
          if (w_step_x) r_x <= r_sx_neg ? (r_x - X_W'(1)) : (r_x + X_W'(1));
          if (w_step_y) r_y <= r_sy_neg ? (r_y - Y_W'(1)) : (r_y + Y_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.pix_we    = (r_state == DRAW);
  assign bus.pix_x     = r_x;
  assign bus.pix_y     = r_y;
  assign bus.pix_color = r_color;
  assign bus.dropped   = w_dropped;

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed bench for line_draw_engine: table of lines plus GO-while-busy and reset-mid-line sequences.
module tb_line_draw_engine;
  import line_draw_pkg::*;

  localparam logic [11:0] BASE = 12'hF00;

  typedef struct {
    int          x0, y0, x1, y1, color, n;
    logic [31:0] ex, ey;  // nibble i holds the x / y of pixel i
    bit          bp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  line_draw_engine_if bus ();

  line_draw_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int got_x[32], got_y[32], got_c[32];
  int got_n, draw_cycles;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nib(input logic [31:0] w, input int i);
    return int'(w[4*i +: 4]);
  endfunction

  // Entered and left on a falling edge; the store is sampled by the rising edge in between.
  task automatic store(input logic [11:0] addr, input logic [31:0] data);
    bus.dmem_address = addr;
    bus.dmem_data_in = data;
    bus.ctrl_DMWE    = 1'b1;
    @(negedge clock);
    bus.ctrl_DMWE    = 1'b0;
  endtask

  task automatic load_line(input int x0, input int y0, input int x1, input int y1, input int c);
    store(BASE + 12'd0, x0);
    store(BASE + 12'd1, y0);
    store(BASE + 12'd2, x1);
    store(BASE + 12'd3, y1);
    store(BASE + 12'd4, c);
  endtask

  // Accepts pixels until pix_we falls; bp applies a 1,0,0 ready pattern and checks stall stability.
  task automatic collect(input bit bp);
    int c = 0;
    bit stalled = 1'b0;
    logic [31:0] hx = '0, hy = '0, hc = '0;
    got_n = 0;
    draw_cycles = 0;
    while (c < 200) begin
      bus.pix_ready = bp ? (c % 3 == 0) : 1'b1;
      if (!bus.pix_we) break;
      if (stalled) begin
        check("stall_x", bus.pix_x, hx);
        check("stall_y", bus.pix_y, hy);
        check("stall_color", bus.pix_color, hc);
      end
      if (bus.pix_ready) begin
        if (got_n < 32) begin
          got_x[got_n] = bus.pix_x;
          got_y[got_n] = bus.pix_y;
          got_c[got_n] = bus.pix_color;
        end
        got_n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hx = bus.pix_x;
        hy = bus.pix_y;
        hc = bus.pix_color;
      end
      draw_cycles++;
      @(negedge clock);
      c++;
    end
    bus.pix_ready = 1'b1;
    check("collect_in_budget", c < 200, 1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    load_line(v.x0, v.y0, v.x1, v.y1, v.color);
    store(BASE + 12'd5, 32'hDEAD_BEEF);
    check($sformatf("v%0d_setup_busy", k), bus.busy, 1);
    check($sformatf("v%0d_setup_we", k), bus.pix_we, 0);
    @(negedge clock);
    collect(v.bp);
    check($sformatf("v%0d_count", k), got_n, v.n);
    for (int i = 0; i < v.n && i < 32; i++) begin
      check($sformatf("v%0d_px%0d_x", k, i), got_x[i], nib(v.ex, i));
      check($sformatf("v%0d_px%0d_y", k, i), got_y[i], nib(v.ey, i));
      check($sformatf("v%0d_px%0d_color", k, i), got_c[i], v.color);
    end
    if (!v.bp) check($sformatf("v%0d_draw_cycles", k), draw_cycles, v.n);
    check($sformatf("v%0d_busy_done", k), bus.busy, 0);
    @(negedge clock);
    check($sformatf("v%0d_quiet", k), bus.pix_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           x0 y0 x1 y1 color n  ex            ey            bp
    vecs[0] = '{0, 0, 3, 0, 5,   4, 32'h0000_3210, 32'h0000_0000, 1'b0};
    vecs[1] = '{0, 0, 1, 3, 17,  4, 32'h0000_1100, 32'h0000_3210, 1'b0};
    vecs[2] = '{5, 5, 2, 2, 200, 4, 32'h0000_2345, 32'h0000_2345, 1'b0};
    vecs[3] = '{7, 9, 7, 9, 66,  1, 32'h0000_0007, 32'h0000_0009, 1'b0};
    vecs[4] = '{0, 0, 4, 1, 255, 5, 32'h0004_3210, 32'h0001_1100, 1'b0};
    vecs[5] = '{3, 0, 0, 2, 9,   4, 32'h0000_0123, 32'h0000_2110, 1'b0};
    vecs[6] = '{0, 0, 3, 0, 5,   4, 32'h0000_3210, 32'h0000_0000, 1'b1};

    reset            = 1'b1;
    bus.dmem_address = '0;
    bus.dmem_data_in = '0;
    bus.ctrl_DMWE    = 1'b0;
    bus.pix_ready    = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_dropped", bus.dropped, 0);
    check("rst_we", bus.pix_we, 0);
    check("rst_xyc", {bus.pix_x, bus.pix_y, bus.pix_color}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Stores that must not start a line: outside the window, or GO address without enable.
    store(12'hF06, 32'd0);
    store(12'h705, 32'd0);
    store(12'hEFF, 32'd0);
    bus.dmem_address = BASE + 12'd5;
    @(negedge clock);
    check("no_start_busy", bus.busy, 0);
    check("no_start_we", bus.pix_we, 0);

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // GO while busy is dropped; X1 written mid-line only affects the next line.
    load_line(0, 0, 3, 0, 8'hA5);
    store(BASE + 12'd5, 32'd0);
    check("gb_setup_busy", bus.busy, 1);
    bus.dmem_address = BASE + 12'd2;
    bus.dmem_data_in = 32'd9;
    bus.ctrl_DMWE    = 1'b1;
    @(negedge clock);
    check("gb_px0_x", bus.pix_x, 0);
    check("gb_px0_we", bus.pix_we, 1);
    check("gb_no_drop_yet", bus.dropped, 0);
    bus.dmem_address = BASE + 12'd5;
    @(negedge clock);
    bus.ctrl_DMWE = 1'b0;
    check("gb_dropped", bus.dropped, 1);
    check("gb_px1_x", bus.pix_x, 1);
    @(negedge clock);
    check("gb_drop_pulse_end", bus.dropped, 0);
    check("gb_px2_x", bus.pix_x, 2);
    @(negedge clock);
    check("gb_px3_x", bus.pix_x, 3);
    check("gb_px3_we", bus.pix_we, 1);
    @(negedge clock);
    check("gb_end_busy", bus.busy, 0);
    check("gb_end_we", bus.pix_we, 0);
    store(BASE + 12'd5, 32'd0);
    @(negedge clock);
    collect(1'b0);
    check("gb_next_count", got_n, 10);
    check("gb_next_first_x", got_x[0], 0);
    check("gb_next_last_x", got_x[9], 9);
    check("gb_next_last_y", got_y[9], 0);
    check("gb_next_color", got_c[9], 8'hA5);
    @(negedge clock);

    // Reset on the second pixel abandons the line and clears the shadow registers.
    load_line(0, 0, 3, 0, 5);
    store(BASE + 12'd5, 32'd0);
    @(negedge clock);
    @(negedge clock);
    check("rm_px1_x", bus.pix_x, 1);
    reset = 1'b1;
    #1;
    check("rm_we", bus.pix_we, 0);
    check("rm_busy", bus.busy, 0);
    check("rm_xyc", {bus.pix_x, bus.pix_y, bus.pix_color}, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("rm_quiet%0d", i), {bus.pix_we, bus.busy}, 0);
    end
    store(BASE + 12'd5, 32'd0);
    @(negedge clock);
    collect(1'b0);
    check("rm_go_count", got_n, 1);
    check("rm_go_xyc", {got_x[0][9:0], got_y[0][8:0], got_c[0][7:0]}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
